// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit
// Consumer end of the pipelined exception path. Prioritises the exception
// flags and pending interrupts of the instruction in MEM, updates the CP0
// registers, and requests a pipeline flush plus PC redirect. Also holds the
// CP0 register file (MTC0 from WB, MFC0 from EXE) and the Count/Compare timer.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   MEM_*               instruction currently in MEM (valid, exception flags,
//                       PC, data address, store, delay slot, ERET)
//   Ext_Int             level-sensitive hardware interrupt lines
//   WB_CP0Wr/Addr/OutB  MTC0 write port
//   EXE_CP0RdAddr       MFC0 read address, CP0_RdData is its combinational data
//   MEM_Flush, Redirect_Valid, Redirect_PC   single-cycle flush/redirect
//   CP0_Status, CP0_Cause, CP0_EPC           current register values
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    input  logic [5:0]  MEM_ExceptType,
    input  logic [31:0] MEM_PC,
    input  logic [31:0] MEM_ALUOut,
    input  logic        MEM_DMWr,
    input  logic        MEM_IsInDelaySlot,
    input  logic        MEM_IsEret,
    input  logic [5:0]  Ext_Int,
    input  logic        WB_CP0Wr,
    input  logic [4:0]  WB_CP0Addr,
    input  logic [31:0] WB_OutB,
    input  logic [4:0]  EXE_CP0RdAddr,
    output logic [31:0] CP0_RdData,
    output logic        MEM_Flush,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC,
    output logic [31:0] CP0_Status,
    output logic [31:0] CP0_Cause,
    output logic [31:0] CP0_EPC
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    // Divider phase value on which Count advances (always 0 when COUNT_DIV is 1).
    localparam logic DIV_LAST = (COUNT_DIV == 2) ? 1'b1 : 1'b0;

    // Architectural state, kept as the individual writable/updatable fields.
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic        div_q, div_d;

    // Register values with the same-cycle WB write already merged in.
    logic        wr_count_s, wr_compare_s, wr_status_s, wr_cause_s, wr_epc_s;
    logic [31:0] count_w_s, compare_w_s, epc_w_s;
    logic [7:0]  im_w_s;
    logic        exl_w_s, ie_w_s;
    logic [1:0]  ip_sw_w_s;

    logic        int_pend_s;
    logic        exc_taken_s;
    logic [4:0]  exc_code_s;
    logic        bad_pc_s, bad_alu_s;
    logic        eret_take_s;
    logic        tick_s;

    function automatic logic [31:0] status_word(input logic [7:0] im, input logic exl,
                                                input logic ie);
        return {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
    endfunction

    function automatic logic [31:0] cause_word(input logic bd, input logic ti,
                                               input logic [5:0] ip_hw, input logic [1:0] ip_sw,
                                               input logic [4:0] exccode);
        return {bd, ti, 14'd0, ip_hw, ip_sw, 1'b0, exccode, 2'd0};
    endfunction

    // Merge the WB MTC0 write into the register view (write masks applied).
    always_comb begin
        wr_count_s   = WB_CP0Wr && (WB_CP0Addr == ADDR_COUNT);
        wr_compare_s = WB_CP0Wr && (WB_CP0Addr == ADDR_COMPARE);
        wr_status_s  = WB_CP0Wr && (WB_CP0Addr == ADDR_STATUS);
        wr_cause_s   = WB_CP0Wr && (WB_CP0Addr == ADDR_CAUSE);
        wr_epc_s     = WB_CP0Wr && (WB_CP0Addr == ADDR_EPC);
        count_w_s    = wr_count_s   ? WB_OutB : count_q;
        compare_w_s  = wr_compare_s ? WB_OutB : compare_q;
        epc_w_s      = wr_epc_s     ? WB_OutB : epc_q;
        ip_sw_w_s    = wr_cause_s   ? WB_OutB[9:8] : ip_sw_q;
        if (wr_status_s) begin
            im_w_s  = WB_OutB[15:8];
            exl_w_s = WB_OutB[1];
            ie_w_s  = WB_OutB[0];
        end else begin
            im_w_s  = im_q;
            exl_w_s = exl_q;
            ie_w_s  = ie_q;
        end
    end

    // Priority-encode the interrupt and the MEM exception flags.
    always_comb begin
        int_pend_s  = MEM_Valid && ((({ip_hw_q, ip_sw_w_s}) & im_w_s) != 8'd0)
                      && ie_w_s && !exl_w_s;
        exc_taken_s = 1'b1;
        exc_code_s  = 5'h00;
        bad_pc_s    = 1'b0;
        bad_alu_s   = 1'b0;
        if (!MEM_Valid) begin
            exc_taken_s = 1'b0;
        end else if (int_pend_s) begin
            exc_code_s = 5'h00;
        end else if (MEM_ExceptType[5]) begin
            exc_code_s = 5'h04;
            bad_pc_s   = 1'b1;
        end else if (MEM_ExceptType[4]) begin
            exc_code_s = 5'h0A;
        end else if (MEM_ExceptType[3]) begin
            exc_code_s = 5'h0C;
        end else if (MEM_ExceptType[2]) begin
            exc_code_s = 5'h08;
        end else if (MEM_ExceptType[1]) begin
            exc_code_s = 5'h09;
        end else if (MEM_ExceptType[0]) begin
            exc_code_s = MEM_DMWr ? 5'h05 : 5'h04;
            bad_alu_s  = 1'b1;
        end else begin
            exc_taken_s = 1'b0;
        end
        eret_take_s = MEM_Valid && MEM_IsEret && !exc_taken_s;
    end

    // Flush/redirect pulse; an exception always beats ERET.
    always_comb begin
        MEM_Flush      = 1'b0;
        Redirect_Valid = 1'b0;
        Redirect_PC    = 32'd0;
        if (!rst) begin
            MEM_Flush      = 1'b0;
            Redirect_Valid = 1'b0;
            Redirect_PC    = 32'd0;
        end else if (exc_taken_s) begin
            MEM_Flush      = 1'b1;
            Redirect_Valid = 1'b1;
            Redirect_PC    = EXC_VECTOR;
        end else if (eret_take_s) begin
            MEM_Flush      = 1'b1;
            Redirect_Valid = 1'b1;
            Redirect_PC    = epc_w_s;
        end else begin
            MEM_Flush      = 1'b0;
            Redirect_Valid = 1'b0;
            Redirect_PC    = 32'd0;
        end
    end

    // MFC0 read port, bypassing a same-cycle MTC0.
    always_comb begin
        case (EXE_CP0RdAddr)
            ADDR_BADVADDR: CP0_RdData = badvaddr_q;
            ADDR_COUNT:    CP0_RdData = count_w_s;
            ADDR_COMPARE:  CP0_RdData = compare_w_s;
            ADDR_STATUS:   CP0_RdData = status_word(im_w_s, exl_w_s, ie_w_s);
            ADDR_CAUSE:    CP0_RdData = cause_word(bd_q, ti_q, ip_hw_q, ip_sw_w_s, exccode_q);
            ADDR_EPC:      CP0_RdData = epc_w_s;
            default:       CP0_RdData = 32'd0;
        endcase
    end

    // Next-state: WB write first, then timer, then exception/ERET overrides.
    always_comb begin
        tick_s    = (div_q == DIV_LAST);
        div_d     = tick_s ? 1'b0 : (div_q + 1'b1);
        badvaddr_d = badvaddr_q;
        compare_d = compare_w_s;
        im_d      = im_w_s;
        ie_d      = ie_w_s;
        exl_d     = exl_w_s;
        ip_sw_d   = ip_sw_w_s;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_w_s;
        // TI feeds IP7 with a one-cycle sampling delay, like the pins.
        ip_hw_d   = {Ext_Int[5] | ti_q, Ext_Int[4:0]};

        if (wr_count_s) begin
            count_d = WB_OutB;
        end else if (tick_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        // Match is only detected on an increment, so a fresh reset (0 == 0) does not fire.
        if (wr_compare_s) begin
            ti_d = 1'b0;
        end else if (tick_s && !wr_count_s && ((count_q + 32'd1) == compare_q)) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end

        if (exc_taken_s) begin
            exccode_d = exc_code_s;
            exl_d     = 1'b1;
            // A nested exception keeps the original return point.
            if (!exl_w_s) begin
                epc_d = MEM_IsInDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
                bd_d  = MEM_IsInDelaySlot;
            end else begin
                epc_d = epc_w_s;
                bd_d  = bd_q;
            end
            if (bad_pc_s) begin
                badvaddr_d = MEM_PC;
            end else if (bad_alu_s) begin
                badvaddr_d = MEM_ALUOut;
            end else begin
                badvaddr_d = badvaddr_q;
            end
        end else if (eret_take_s) begin
            exl_d = 1'b0;
        end else begin
            exl_d = exl_w_s;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= 6'd0;
            ip_sw_q    <= 2'd0;
            exccode_q  <= 5'd0;
            epc_q      <= 32'd0;
            div_q      <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            div_q      <= div_d;
        end
    end

    // Registered views of the main control registers.
    always_comb begin
        CP0_Status = status_word(im_q, exl_q, ie_q);
        CP0_Cause  = cause_word(bd_q, ti_q, ip_hw_q, ip_sw_q, exccode_q);
        CP0_EPC    = epc_q;
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: directed scenarios plus a randomized run
// checked against a word-level reference model of the CP0 registers.
module tb_cp0_exception_unit;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          DIV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_dmwr, mem_ds, mem_eret;
    logic [5:0]  mem_except, ext_int;
    logic [31:0] mem_pc, mem_alu;
    logic        wb_wr;
    logic [4:0]  wb_addr, exe_rd;
    logic [31:0] wb_data;

    logic [31:0] CP0_RdData, Redirect_PC, CP0_Status, CP0_Cause, CP0_EPC;
    logic        MEM_Flush, Redirect_Valid;

    int errors = 0;
    int checks = 0;

    cp0_exception_unit #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
        .clk(clk), .rst(rst),
        .MEM_Valid(mem_valid), .MEM_ExceptType(mem_except), .MEM_PC(mem_pc),
        .MEM_ALUOut(mem_alu), .MEM_DMWr(mem_dmwr), .MEM_IsInDelaySlot(mem_ds),
        .MEM_IsEret(mem_eret), .Ext_Int(ext_int),
        .WB_CP0Wr(wb_wr), .WB_CP0Addr(wb_addr), .WB_OutB(wb_data),
        .EXE_CP0RdAddr(exe_rd), .CP0_RdData(CP0_RdData),
        .MEM_Flush(MEM_Flush), .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC),
        .CP0_Status(CP0_Status), .CP0_Cause(CP0_Cause), .CP0_EPC(CP0_EPC)
    );

    always #5 clk = ~clk;

    // Reference model: whole 32-bit register words as software sees them.
    logic [31:0] m_badv = 32'd0, m_count = 32'd0, m_cmp = 32'd0;
    logic [31:0] m_status = 32'h0040_0000, m_cause = 32'd0, m_epc = 32'd0;
    int          m_cycles = 0;
    logic [31:0] w_status, w_cause, w_epc, w_count, w_cmp;
    logic        wr_cnt, wr_cmp;
    logic        e_exc, e_int, e_eret, e_flush;
    logic [4:0]  e_code;
    int          e_bad;    // 0 none, 1 from PC, 2 from data address
    logic [31:0] e_rpc, e_rd;

    task automatic model_eval();
        wr_cnt   = wb_wr && (wb_addr == 5'd9);
        wr_cmp   = wb_wr && (wb_addr == 5'd11);
        w_status = (wb_wr && wb_addr == 5'd12) ?
                   ((m_status & ~32'h0000_FF03) | (wb_data & 32'h0000_FF03)) : m_status;
        w_cause  = (wb_wr && wb_addr == 5'd13) ?
                   ((m_cause & ~32'h0000_0300) | (wb_data & 32'h0000_0300)) : m_cause;
        w_epc    = (wb_wr && wb_addr == 5'd14) ? wb_data : m_epc;
        w_count  = wr_cnt ? wb_data : m_count;
        w_cmp    = wr_cmp ? wb_data : m_cmp;
        e_int = mem_valid && ((w_cause[15:8] & w_status[15:8]) != 8'd0)
                && w_status[0] && !w_status[1];
        e_exc = 1'b0; e_code = 5'd0; e_bad = 0;
        if (mem_valid && e_int) begin
            e_exc = 1'b1;
        end
        for (int i = 5; i >= 0; i--) begin
            if (mem_valid && !e_exc && mem_except[i]) begin
                e_exc = 1'b1;
                case (i)
                    5: begin e_code = 5'h04; e_bad = 1; end
                    4: e_code = 5'h0A;
                    3: e_code = 5'h0C;
                    2: e_code = 5'h08;
                    1: e_code = 5'h09;
                    default: begin e_code = mem_dmwr ? 5'h05 : 5'h04; e_bad = 2; end
                endcase
            end
        end
        e_eret  = mem_valid && mem_eret && !e_exc;
        e_flush = rst && (e_exc || e_eret);
        e_rpc   = (!rst) ? 32'd0 : (e_exc ? VEC : (e_eret ? w_epc : 32'd0));
        case (exe_rd)
            5'd8:    e_rd = m_badv;
            5'd9:    e_rd = w_count;
            5'd11:   e_rd = w_cmp;
            5'd12:   e_rd = w_status;
            5'd13:   e_rd = w_cause;
            5'd14:   e_rd = w_epc;
            default: e_rd = 32'd0;
        endcase
    endtask

    task automatic model_commit();
        logic [31:0] nc;
        logic        tick, old_ti;
        if (!rst) begin
            m_badv = 32'd0; m_count = 32'd0; m_cmp = 32'd0;
            m_status = 32'h0040_0000; m_cause = 32'd0; m_epc = 32'd0; m_cycles = 0;
        end else begin
            tick = ((m_cycles % DIV) == DIV - 1);
            m_cycles++;
            old_ti = m_cause[30];
            nc = w_cause;
            if (wr_cmp) nc[30] = 1'b0;
            else if (tick && !wr_cnt && (m_count + 32'd1) == m_cmp) nc[30] = 1'b1;
            m_count = wr_cnt ? wb_data : (tick ? m_count + 32'd1 : m_count);
            m_cmp = w_cmp;
            nc[15:10] = {ext_int[5] | old_ti, ext_int[4:0]};
            m_status = w_status;
            m_epc = w_epc;
            if (e_exc) begin
                nc[6:2] = e_code;
                if (!w_status[1]) begin
                    m_epc = mem_ds ? mem_pc - 32'd4 : mem_pc;
                    nc[31] = mem_ds;
                end
                m_status[1] = 1'b1;
                if (e_bad == 1) m_badv = mem_pc;
                if (e_bad == 2) m_badv = mem_alu;
            end else if (e_eret) begin
                m_status[1] = 1'b0;
            end
            m_cause = nc;
        end
    endtask

    task automatic settle();
        model_eval();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0; mem_except = 6'd0; mem_pc = 32'd0; mem_alu = 32'd0;
        mem_dmwr = 1'b0; mem_ds = 1'b0; mem_eret = 1'b0; ext_int = 6'd0;
        wb_wr = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; exe_rd = 5'd0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        wb_wr = 1'b1; wb_addr = a; wb_data = d;
        settle();
        advance();
        idle();
    endtask

    task automatic test_reset();
        logic [4:0] addrs [6];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        idle();
        rst = 1'b0; mem_valid = 1'b1; mem_except = 6'b100000; mem_eret = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (MEM_Flush !== 1'b0 || Redirect_Valid !== 1'b0 || Redirect_PC !== 32'd0) begin
                errors++;
                $display("FAIL reset_redirect got flush=%0b rv=%0b pc=%h want 0/0/0",
                         MEM_Flush, Redirect_Valid, Redirect_PC);
            end
            advance();
        end
        idle();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exe_rd = addrs[k];
            settle();
            checks++;
            if (CP0_RdData !== ((addrs[k] == 5'd12) ? 32'h0040_0000 : e_rd) ||
                (addrs[k] != 5'd9 && addrs[k] != 5'd12 && CP0_RdData !== 32'd0)) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h want=%h", addrs[k], CP0_RdData, e_rd);
            end
            checks++;
            if (MEM_Flush !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush got=%0b want=0", MEM_Flush);
            end
            advance();
        end
    endtask

    task automatic test_overflow();
        idle();
        mem_valid = 1'b1; mem_except = 6'b001000; mem_pc = 32'hBFC0_0100;
        settle();
        checks++;
        if (MEM_Flush !== 1'b1 || Redirect_Valid !== 1'b1 || Redirect_PC !== 32'hBFC0_0380) begin
            errors++;
            $display("FAIL ovf_redirect got flush=%0b rv=%0b pc=%h want 1/1/bfc00380",
                     MEM_Flush, Redirect_Valid, Redirect_PC);
        end
        advance();
        idle();
        settle();
        checks++;
        if (CP0_EPC !== 32'hBFC0_0100 || CP0_Cause[6:2] !== 5'h0C || CP0_Status[1] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_regs got epc=%h code=%h exl=%0b want bfc00100/0c/1",
                     CP0_EPC, CP0_Cause[6:2], CP0_Status[1]);
        end
        advance();
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_store_badaddr();
        idle();
        mem_valid = 1'b1; mem_except = 6'b000001; mem_dmwr = 1'b1; mem_alu = 32'h0000_0003;
        mem_ds = 1'b1; mem_pc = 32'h8000_0010;
        settle();
        checks++;
        if (Redirect_Valid !== 1'b1 || Redirect_PC !== VEC) begin
            errors++;
            $display("FAIL st_redirect got rv=%0b pc=%h want 1/%h", Redirect_Valid, Redirect_PC, VEC);
        end
        advance();
        idle();
        exe_rd = 5'd8;
        settle();
        checks++;
        if (CP0_RdData !== 32'd3 || CP0_Cause[6:2] !== 5'h05 || CP0_EPC !== 32'h8000_000C ||
            CP0_Cause[31] !== 1'b1) begin
            errors++;
            $display("FAIL st_regs got badv=%h code=%h epc=%h bd=%0b want 3/05/8000000c/1",
                     CP0_RdData, CP0_Cause[6:2], CP0_EPC, CP0_Cause[31]);
        end
        advance();
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_priority_nested();
        idle();
        mem_valid = 1'b1; mem_except = 6'b010100; mem_pc = 32'h0000_0100;
        settle();
        advance();
        idle();
        settle();
        checks++;
        if (CP0_Cause[6:2] !== 5'h0A || CP0_EPC !== 32'h0000_0100) begin
            errors++;
            $display("FAIL prio_code got code=%h epc=%h want 0a/00000100", CP0_Cause[6:2], CP0_EPC);
        end
        advance();
        mem_valid = 1'b1; mem_except = 6'b000010; mem_pc = 32'h0000_0200; mem_ds = 1'b1;
        settle();
        checks++;
        if (MEM_Flush !== 1'b1) begin
            errors++;
            $display("FAIL nested_flush got=%0b want=1", MEM_Flush);
        end
        advance();
        idle();
        settle();
        checks++;
        if (CP0_EPC !== 32'h0000_0100 || CP0_Cause[6:2] !== 5'h09 || CP0_Cause[31] !== 1'b0) begin
            errors++;
            $display("FAIL nested_epc got epc=%h code=%h bd=%0b want 00000100/09/0",
                     CP0_EPC, CP0_Cause[6:2], CP0_Cause[31]);
        end
        advance();
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_timer();
        logic seen;
        seen = 1'b0;
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd10);
        exe_rd = 5'd9;
        for (int c = 0; c < 60 && !seen; c++) begin
            settle();
            if (CP0_Cause[30] === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (CP0_RdData !== 32'd10) begin
                    errors++;
                    $display("FAIL timer_count got=%0d want=10", CP0_RdData);
                end
            end
            advance();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timer_ti got=0 want=1 within 60 cycles");
        end
        idle();
        mem_valid = 1'b1; mem_pc = 32'h0000_0300;
        settle();
        checks++;
        if (MEM_Flush !== 1'b1 || Redirect_PC !== VEC) begin
            errors++;
            $display("FAIL timer_int got flush=%0b pc=%h want 1/%h", MEM_Flush, Redirect_PC, VEC);
        end
        advance();
        idle();
        settle();
        checks++;
        if (CP0_Cause[6:2] !== 5'h00 || CP0_EPC !== 32'h0000_0300) begin
            errors++;
            $display("FAIL timer_code got code=%h epc=%h want 00/00000300", CP0_Cause[6:2], CP0_EPC);
        end
        advance();
        mtc0(5'd11, 32'hFFFF_0000);
        settle();
        checks++;
        if (CP0_Cause[30] !== 1'b0) begin
            errors++;
            $display("FAIL timer_clear got ti=%0b want=0", CP0_Cause[30]);
        end
        advance();
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_eret_bypass();
        mtc0(5'd12, 32'h0000_0002);
        mem_valid = 1'b1; mem_eret = 1'b1; mem_pc = 32'h0000_0500;
        wb_wr = 1'b1; wb_addr = 5'd14; wb_data = 32'h8000_2000;
        settle();
        checks++;
        if (MEM_Flush !== 1'b1 || Redirect_Valid !== 1'b1 || Redirect_PC !== 32'h8000_2000) begin
            errors++;
            $display("FAIL eret_redirect got flush=%0b rv=%0b pc=%h want 1/1/80002000",
                     MEM_Flush, Redirect_Valid, Redirect_PC);
        end
        advance();
        idle();
        settle();
        checks++;
        if (MEM_Flush !== 1'b0 || Redirect_Valid !== 1'b0 || CP0_Status[1] !== 1'b0 ||
            CP0_EPC !== 32'h8000_2000) begin
            errors++;
            $display("FAIL eret_after got flush=%0b rv=%0b exl=%0b epc=%h want 0/0/0/80002000",
                     MEM_Flush, Redirect_Valid, CP0_Status[1], CP0_EPC);
        end
        advance();
    endtask

    task automatic test_reset_mid_exception();
        idle();
        mtc0(5'd14, 32'h1234_5678);
        mem_valid = 1'b1; mem_except = 6'b001000; mem_pc = 32'h0000_0700;
        rst = 1'b0;
        settle();
        checks++;
        if (MEM_Flush !== 1'b0 || Redirect_Valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_redirect got flush=%0b rv=%0b want 0/0", MEM_Flush, Redirect_Valid);
        end
        advance();
        rst = 1'b1;
        idle();
        settle();
        checks++;
        if (CP0_Status !== 32'h0040_0000 || CP0_Cause !== 32'd0 || CP0_EPC !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_regs got st=%h ca=%h epc=%h want 00400000/0/0",
                     CP0_Status, CP0_Cause, CP0_EPC);
        end
        advance();
    endtask

    task automatic test_random();
        logic [4:0] pick [7];
        pick = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 79) != 0);
            mem_valid  = $urandom_range(0, 1) == 1;
            mem_except = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'd0;
            mem_pc     = $urandom();
            mem_alu    = $urandom();
            mem_dmwr   = $urandom_range(0, 1) == 1;
            mem_ds     = $urandom_range(0, 1) == 1;
            mem_eret   = $urandom_range(0, 5) == 0;
            ext_int    = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : 6'd0;
            wb_wr      = $urandom_range(0, 2) == 0;
            wb_addr    = pick[$urandom_range(0, 6)];
            wb_data    = (wb_addr == 5'd9 || wb_addr == 5'd11) ? 32'($urandom_range(0, 40))
                                                               : $urandom();
            exe_rd     = pick[$urandom_range(0, 6)];
            settle();
            checks++;
            if (MEM_Flush !== e_flush || Redirect_Valid !== e_flush) begin
                errors++;
                $display("FAIL rnd_flush cyc=%0d got flush=%0b rv=%0b want=%0b",
                         c, MEM_Flush, Redirect_Valid, e_flush);
            end
            if (e_flush || !rst) begin
                checks++;
                if (Redirect_PC !== e_rpc) begin
                    errors++;
                    $display("FAIL rnd_pc cyc=%0d got=%h want=%h", c, Redirect_PC, e_rpc);
                end
            end
            if (rst) begin
                checks++;
                if (CP0_RdData !== e_rd) begin
                    errors++;
                    $display("FAIL rnd_rd cyc=%0d addr=%0d got=%h want=%h", c, exe_rd, CP0_RdData, e_rd);
                end
            end
            checks++;
            if (CP0_Status !== m_status || CP0_Cause !== m_cause || CP0_EPC !== m_epc) begin
                errors++;
                $display("FAIL rnd_regs cyc=%0d got %h/%h/%h want %h/%h/%h", c,
                         CP0_Status, CP0_Cause, CP0_EPC, m_status, m_cause, m_epc);
            end
            advance();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_overflow();
        test_store_badaddr();
        test_priority_nested();
        test_timer();
        test_eret_bypass();
        test_reset_mid_exception();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Consumer end of the exception path carried down the pipeline registers.
- Takes the ExceptinPipeType vector, PC and context of the instruction in MEM, plus external interrupts. Prioritises them, updates the CP0 registers and drives the pipeline flush and PC redirect.
- Also hosts the CP0 register file: MTC0 writes from WB, MFC0 reads from EXE, and the Count/Compare timer.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for every exception and interrupt.
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (legal values 1 or 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- MEM_Valid  in  1  MEM holds a real instruction (not a bubble)
- MEM_ExceptType  in  6  {WrongAddressinIF, ReservedInstruction, Overflow, Syscall, Break, WrongAddressinMEM}; MSB first
- MEM_PC  in  32  PC of the MEM instruction
- MEM_ALUOut  in  32  data address of the MEM instruction
- MEM_DMWr  in  1  MEM instruction is a store
- MEM_IsInDelaySlot  in  1  MEM instruction sits in a branch delay slot
- MEM_IsEret  in  1  MEM instruction is ERET
- Ext_Int  in  6  hardware interrupt lines, level-sensitive
- WB_CP0Wr  in  1  MTC0 write enable (RegsWrType.CP0Wr)
- WB_CP0Addr  in  5  MTC0 register number
- WB_OutB  in  32  MTC0 write data
- EXE_CP0RdAddr  in  5  MFC0 register number
- CP0_RdData  out  32  MFC0 read data
- MEM_Flush  out  1  flush IF/ID/EXE/MEM pipeline registers
- Redirect_Valid  out  1  PC redirect request
- Redirect_PC  out  32  redirect target
- CP0_Status  out  32  Status register
- CP0_Cause  out  32  Cause register
- CP0_EPC  out  32  EPC register

Behaviour:
- Reset: rst is synchronous and active-low, evaluated on the rising edge of clk.
  - Register values after reset: BadVAddr=0, Count=0, Compare=0, Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, divider phase=0.
  - MEM_Flush, Redirect_Valid and Redirect_PC are combinational, and are 0 while rst is low.
- Implemented registers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
  - Unimplemented addresses read 0 and ignore writes.
- Write masks:
  - Status: only IM[15:8], EXL[1] and IE[0] are writable; BEV[22] is stuck at 1.
  - Cause: only IP[9:8] is writable. BD[31], TI[30], IP[15:10] and ExcCode[6:2] are read-only.
  - BadVAddr is not writable by MTC0.
- Cause.IP[15:10] is {Ext_Int[5] | TI, Ext_Int[4:0]}, sampled every cycle.
- Timer:
  - Count increments on the last cycle of each COUNT_DIV period.
  - When Count equals Compare after the update, TI is set to 1.
  - An MTC0 write to Compare clears TI.
  - An MTC0 write to Count wins over the same-cycle increment.
- Interrupt pending condition: (Cause.IP & Status.IM) != 0, Status.IE=1, Status.EXL=0 and MEM_Valid=1. The interrupt is attached to the MEM instruction.
- Exception priority and ExcCode (only evaluated when MEM_Valid=1):
  1. Interrupt, 0x00.
  2. WrongAddressinIF, 0x04; BadVAddr<=MEM_PC.
  3. ReservedInstruction, 0x0A.
  4. Overflow, 0x0C.
  5. Syscall, 0x08.
  6. Break, 0x09.
  7. WrongAddressinMEM, 0x04 for a load or 0x05 when MEM_DMWr=1; BadVAddr<=MEM_ALUOut.
- Exception taken, same cycle:
  - MEM_Flush=1, Redirect_Valid=1, Redirect_PC=EXC_VECTOR.
  - At the clock edge: ExcCode is updated and EXL<=1.
  - EPC and BD are updated only if EXL was 0: EPC<=MEM_IsInDelaySlot ? MEM_PC-4 : MEM_PC, BD<=MEM_IsInDelaySlot.
- ERET in MEM with no exception pending:
  - MEM_Flush=1, Redirect_Valid=1, Redirect_PC=EPC; EXL<=0 at the edge.
  - If WB writes EPC in the same cycle, Redirect_PC uses WB_OutB.
  - A pending exception takes precedence over ERET.
- Flush and redirect are single-cycle pulses. They never assert when MEM_Valid=0.
- Simultaneous MTC0 in WB and exception in MEM: the WB write is applied first. Exception-updated fields (EPC, BD, ExcCode, EXL, BadVAddr) then override it.
- Interrupt evaluation uses the post-write Status/Cause values as seen combinationally, so an MTC0 that sets IE takes effect for the instruction in MEM in the same cycle.
- CP0_RdData is a combinational read of EXE_CP0RdAddr. It bypasses a same-cycle WB write to the same address, with the write mask applied.
- Reset asserted mid-exception: all state returns to its reset value; no redirect is issued.

Test Plan:
- Reset, then read all registers → Status=32'h0040_0000, all others 0; MEM_Flush=0.
- Overflow at MEM_PC=32'hBFC0_0100, not in a delay slot → flush and redirect to 32'hBFC0_0380; EPC=32'hBFC0_0100, ExcCode=0x0C, EXL=1.
- Store with WrongAddressinMEM, MEM_ALUOut=32'h0000_0003, delay slot=1, MEM_PC=32'h8000_0010 → BadVAddr=3, ExcCode=0x05, EPC=32'h8000_000C, BD=1.
- Both Syscall and ReservedInstruction set → ExcCode=0x0A. A second exception taken while EXL=1 leaves EPC unchanged.
- MTC0 Status=32'h0000_8001, Compare=10, COUNT_DIV=2 → TI=1 when Count reaches 10 (about cycle 20). The next valid MEM instruction takes an interrupt with ExcCode=0x00. Writing Compare clears TI.
- WB MTC0 EPC=32'h8000_2000 in the same cycle ERET is in MEM → Redirect_PC=32'h8000_2000, EXL=0, flush for exactly one cycle.
